// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests, buffers words in a
// 2-entry queue. Optional macro FETCH_BYPASS_EN forwards a response combinationally when empty.
module fetch_pc_unit #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          o_imem_req,
  output logic [AW-1:0] o_imem_addr,
  input  logic          i_imem_gnt,
  input  logic          i_imem_rvalid,
  input  logic [DW-1:0] i_imem_rdata,
  input  logic          i_redirect_valid,
  input  logic [AW-1:0] i_redirect_pc,
  output logic          o_inst_valid,
  input  logic          i_inst_ready,
  output logic [DW-1:0] o_inst,
  output logic [AW-1:0] o_inst_pc
);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_resp_pc;
  logic [1:0]    r_outstanding;
  logic [1:0]    r_drop;
  logic [1:0]    r_count;
  logic          r_head;
  logic [DW-1:0] r_q_inst [2];
  logic [AW-1:0] r_q_pc   [2];

  logic          w_fire;
  logic          w_push;
  logic          w_bypass;
  logic          w_q_push;
  logic          w_q_pop;
  logic          w_tail;
  logic [2:0]    w_credit;
  logic [1:0]    w_outstanding_next;
  logic [AW-1:0] w_redirect_pc;

  // Credit uses registered state only, so a same-cycle pop frees nothing until the next cycle.
  assign w_credit           = {1'b0, r_outstanding} + {1'b0, r_count};
  assign o_imem_req         = rst_n && (w_credit < 3'd2);
  assign o_imem_addr        = r_pc;
  assign w_fire             = o_imem_req && i_imem_gnt;
  assign w_outstanding_next = r_outstanding + {1'b0, w_fire} - {1'b0, i_imem_rvalid};
  assign w_redirect_pc      = {i_redirect_pc[AW-1:2], 2'b00};
  assign w_push             = i_imem_rvalid && (r_drop == 2'd0) && !i_redirect_valid;
  assign w_tail             = r_head ^ r_count[0];

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_push && (r_count == 2'd0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_q_push = w_push && !(w_bypass && i_inst_ready);
  assign w_q_pop  = (r_count != 2'd0) && i_inst_ready && !i_redirect_valid;

  always_comb begin
    o_inst_valid = 1'b0;
    o_inst       = '0;
    o_inst_pc    = '0;
    if (r_count != 2'd0) begin
      o_inst_valid = 1'b1;
      o_inst       = r_q_inst[r_head];
      o_inst_pc    = r_q_pc[r_head];
    end else if (w_bypass) begin
      o_inst_valid = 1'b1;
      o_inst       = i_imem_rdata;
      o_inst_pc    = r_resp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= 2'd0;
      r_drop        <= 2'd0;
      r_count       <= 2'd0;
      r_head        <= 1'b0;
      r_q_inst[0]   <= '0;
      r_q_inst[1]   <= '0;
      r_q_pc[0]     <= '0;
      r_q_pc[1]     <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (i_redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        r_pc      <= w_redirect_pc;
        r_resp_pc <= w_redirect_pc;
        r_drop    <= w_outstanding_next;
        r_count   <= 2'd0;
        r_head    <= 1'b0;
      end else begin
        if (w_fire) r_pc <= r_pc + AW'(4);
        if (i_imem_rvalid && (r_drop != 2'd0)) r_drop <= r_drop - 2'd1;
        if (w_push) r_resp_pc <= r_resp_pc + AW'(4);
        if (w_q_push) begin
          r_q_inst[w_tail] <= i_imem_rdata;
          r_q_pc[w_tail]   <= r_resp_pc;
        end
        if (w_q_pop) r_head <= ~r_head;
        r_count <= r_count + {1'b0, w_q_push} - {1'b0, w_q_pop};
      end
    end
  end

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_q_push && (r_count == 2'd2)))
    else $error("fetch_pc_unit: push into full queue");

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end: owns the program counter, issues in-order requests to instruction memory and buffers returned words in a 2-entry queue. Presents one instruction per handshake, with its PC, to the IF pipeline register directly downstream. Handles branch/jump redirects by flushing the queue and discarding responses still in flight.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `AW`, default 32: address width.
- `DW`, default 32: instruction width.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out AW: fetch address, word aligned.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response data valid.
- `imem_rdata` in DW: response instruction.
- `redirect_valid` in 1: branch/jump redirect.
- `redirect_pc` in AW: redirect target; bits [1:0] ignored and forced to 0.
- `inst_valid` out 1: `inst` / `inst_pc` valid to IF register.
- `inst_ready` in 1: IF register accepts this cycle.
- `inst` out DW: instruction at queue head; 0 when empty.
- `inst_pc` out AW: PC of `inst`; 0 when empty.

## Operation

**State**
- `pc` (AW bits).
- `outstanding` (2 bits): granted requests with no response yet.
- `drop` (2 bits): responses to discard.
- Queue: 2 entries of {`inst`, `pc`}, with `count` (0..2).
- Memory contract: one response per grant, returned in order, no earlier than the cycle after the grant.

**Request issue**
- `imem_req` = `rst_n` released && (`outstanding` + `count` < 2), using registered values only. A pop in the same cycle does not free credit until the next cycle.
- `imem_addr` = `pc`.
- Once `imem_req` is high with `imem_gnt` low, `imem_req` and `imem_addr` stay stable until granted or redirected.
- On `imem_req && imem_gnt`: `pc` <= `pc` + 4, wrapping modulo 2^AW; `outstanding` increments.

**Responses**
- On `imem_rvalid`: `outstanding` decrements.
- If `drop` > 0: the word is discarded and `drop` decrements.
- Otherwise the word is pushed with its PC. Each entry's PC is tracked by a response-PC register advanced by 4 per accepted response and reloaded on redirect.
- Credit guarantees a push never hits a full queue. A push into a full queue is a design error and must be flagged by an assertion in simulation.

**Output**
- Queue head drives `inst` / `inst_pc`; `inst_valid` = (`count` != 0).
- Pop on `inst_valid && inst_ready`.
- Simultaneous push and pop keeps `count` unchanged.

**Redirect** (highest priority)
- `pc` <= `redirect_pc & ~3`.
- Queue flushed: `count` <= 0; a same-cycle pop is ignored.
- `drop` <= `outstanding` + (`imem_req && imem_gnt`) − `imem_rvalid`, so a same-cycle grant is dropped later and a same-cycle response is discarded now.
- An ungranted pending request is abandoned. The next `imem_req` uses the new PC from the following cycle.
- `outstanding` bookkeeping is unaffected by redirect.

## Timing

**Reset values**
- `imem_req` 0, `imem_addr` RESET_PC, `inst_valid` 0, `inst` 0, `inst_pc` 0.
- All counters 0.

**Latency and handshake**
- First `imem_req` occurs in the first clock edge cycle after `rst_n` deasserts.
- Without bypass: grant at t, response at t+1 (earliest), `inst_valid` at t+2.
- Redirect asserted in cycle t: `imem_addr` = target in t+1; stale `inst_valid` low in t+1.
- Reset asserted mid-operation clears all state immediately (asynchronous). Responses arriving while in reset are ignored.

## Configuration

- `FETCH_BYPASS_EN` defined:
  - When the queue is empty and an accepted, non-dropped response arrives, `inst_valid` = 1 and `inst` = `imem_rdata` combinationally in the same cycle.
  - If `inst_ready` is high that cycle, the word is not written to the queue.
  - Saves one cycle of latency at the cost of a combinational path from `imem_rdata` to `inst`.
- Not defined: outputs are driven only from queue registers, so latency is as stated in Timing.

## Test plan

- **Reset, then memory with 1-cycle response and `inst_ready` = 1** -> addresses 0x0, 0x4, 0x8 requested in order. `inst_pc` sequence 0x0, 0x4, 0x8 with matching `inst` words. First `inst_valid` 2 cycles after the first grant (1 cycle with `FETCH_BYPASS_EN`).
- **`inst_ready` held 0** -> `count` reaches 2, `imem_req` drops to 0 and no further grants occur. Releasing `inst_ready` drains 0x0 then 0x4, then requests resume at 0x8.
- **`imem_gnt` held 0 for 3 cycles** -> `imem_req` = 1 and `imem_addr` = 0x0 stable throughout; `pc` advances only after the grant.
- **Redirect to 0x103 with 2 requests outstanding** -> `imem_addr` = 0x100 next cycle. The two stale responses are discarded. The next `inst_pc` is 0x100 and the queue is empty meanwhile.
- **Redirect in the same cycle as a grant and a response** -> the same-cycle response is dropped, `drop` = 1, and the granted request's response is also dropped. The first delivered `inst_pc` is the redirect target.
- **`rst_n` asserted while a response is pending** -> outputs return to reset values asynchronously, and the late `imem_rvalid` has no effect.
